// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard with HALT drain sequencing; optional stall counter via HAZARD_STATS_EN.
// Stall/bubble outputs are combinational; scoreboard and halt FSM advance only on enabled edges.
module hazard_scoreboard #(
    parameter int NB_REG_ADDR  = 5,
    parameter int NB_OP        = 6,
    parameter int LOAD_LATENCY = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_REG_ADDR-1:0]    i_if_id_rs,
    input  logic [NB_REG_ADDR-1:0]    i_if_id_rt,
    input  logic                      i_if_id_rt_used,
    input  logic [NB_OP-1:0]          i_if_id_op,
    input  logic [NB_REG_ADDR-1:0]    i_id_ex_rt,
    input  logic [NB_OP-1:0]          i_id_ex_op,
    input  logic                      i_id_ex_valid,
    output logic                      o_stall,
    output logic                      o_ctr_reg_src,
    output logic                      o_halt_fetch,
    output logic                      o_halted,
    output logic [2**NB_REG_ADDR-1:0] o_busy_mask
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]               o_stall_count
`endif
);

    localparam int NUM_REGS = 2**NB_REG_ADDR;

    localparam logic [NB_OP-1:0] CODE_OP_LB   = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] CODE_OP_LH   = NB_OP'(6'b100001);
    localparam logic [NB_OP-1:0] CODE_OP_LW   = NB_OP'(6'b100011);
    localparam logic [NB_OP-1:0] CODE_OP_LBU  = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] CODE_OP_LHU  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] CODE_OP_LWU  = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] CODE_OP_HALT = NB_OP'(6'b111111);

    localparam logic [2:0] LOAD_INIT  = 3'(LOAD_LATENCY - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic is_load(input logic [NB_OP-1:0] op);
        return (op == CODE_OP_LB)  || (op == CODE_OP_LH)  || (op == CODE_OP_LW) ||
               (op == CODE_OP_LBU) || (op == CODE_OP_LHU) || (op == CODE_OP_LWU);
    endfunction

    logic [2:0] cnt_q [NUM_REGS];
    logic [2:0] cnt_d [NUM_REGS];
    logic [1:0] state_q, state_d;
    logic [3:0] drain_q, drain_d;

    logic ex_load, ex_hit, sb_hit, halted, accept;

    assign ex_load = i_id_ex_valid & is_load(i_id_ex_op) & (i_id_ex_rt != '0);
    assign ex_hit  = ex_load & ((i_id_ex_rt == i_if_id_rs) |
                                (i_if_id_rt_used & (i_id_ex_rt == i_if_id_rt)));
    assign sb_hit  = ((i_if_id_rs != '0) & (cnt_q[i_if_id_rs] != 3'd0)) |
                     (i_if_id_rt_used & (i_if_id_rt != '0) & (cnt_q[i_if_id_rt] != 3'd0));

    assign halted        = (state_q == ST_HALTED);
    assign o_stall       = (ex_hit | sb_hit) & ~halted;
    assign o_ctr_reg_src = o_stall;
    assign o_halted      = halted;

    // HALT is only taken when it can leave ID, i.e. not while it is being stalled.
    assign accept       = (state_q == ST_RUN) & (i_if_id_op == CODE_OP_HALT) & ~o_stall & i_enable;
    assign o_halt_fetch = (state_q != ST_RUN) | accept;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i]       = (cnt_q[i] != 3'd0) ? cnt_q[i] - 3'd1 : 3'd0;
            o_busy_mask[i] = (cnt_q[i] != 3'd0);
            if (ex_load && (i_id_ex_rt == NB_REG_ADDR'(i))) begin
                cnt_d[i] = LOAD_INIT;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (drain_q <= 4'd1) begin
                    state_d = ST_HALTED;
                    drain_d = 4'd0;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_HALTED;
                drain_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= 3'd0;
            end
            state_q <= ST_RUN;
            drain_q <= 4'd0;
        end else if (i_enable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (o_stall && i_enable && !halted && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign o_stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two instances (LOAD_LATENCY 1 and 3) share stimulus,
// checked every cycle against a cycle-count model plus hand-computed literal expectations.
module tb_hazard_scoreboard;

    localparam int NR    = 32;
    localparam int DRAIN = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_LWU  = 6'b100111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, rt_used, vld;
    logic [4:0] rs, rt, exrt;
    logic [5:0] op, exop;

    logic        s1, c1, hf1, hd1, s3, c3, hf3, hd3;
    logic [31:0] m1, m3;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc1, sc3;
`endif

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.NB_REG_ADDR(5), .NB_OP(6), .LOAD_LATENCY(1), .DRAIN_CYCLES(DRAIN)) u1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en),
        .i_if_id_rs(rs), .i_if_id_rt(rt), .i_if_id_rt_used(rt_used), .i_if_id_op(op),
        .i_id_ex_rt(exrt), .i_id_ex_op(exop), .i_id_ex_valid(vld),
        .o_stall(s1), .o_ctr_reg_src(c1), .o_halt_fetch(hf1), .o_halted(hd1), .o_busy_mask(m1)
`ifdef HAZARD_STATS_EN
        , .o_stall_count(sc1)
`endif
    );

    hazard_scoreboard #(.NB_REG_ADDR(5), .NB_OP(6), .LOAD_LATENCY(3), .DRAIN_CYCLES(DRAIN)) u3 (
        .i_clk(clk), .i_reset(rst), .i_enable(en),
        .i_if_id_rs(rs), .i_if_id_rt(rt), .i_if_id_rt_used(rt_used), .i_if_id_op(op),
        .i_id_ex_rt(exrt), .i_id_ex_op(exop), .i_id_ex_valid(vld),
        .o_stall(s3), .o_ctr_reg_src(c3), .o_halt_fetch(hf3), .o_halted(hd3), .o_busy_mask(m3)
`ifdef HAZARD_STATS_EN
        , .o_stall_count(sc3)
`endif
    );

    // Model: E counts enabled edges since reset; a register is busy while E < busy_until.
    int E;
    int bu [2][NR];
    bit accv [2];
    int acc [2];
    int ll [2] = '{1, 3};
    bit model_on = 1'b0;

    function automatic bit m_load(input logic [5:0] o);
        return o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic bit m_busy(input int k, input logic [4:0] r);
        return (r != 5'd0) && (E < bu[k][r]);
    endfunction

    function automatic bit m_halted(input int k);
        return accv[k] && (E >= acc[k] + ((DRAIN > 1) ? DRAIN - 1 : 1));
    endfunction

    function automatic bit m_stall(input int k);
        bit exhit, sbhit;
        exhit = vld && m_load(exop) && (exrt != 5'd0) &&
                ((exrt == rs) || (rt_used && (exrt == rt)));
        sbhit = m_busy(k, rs) || (rt_used && m_busy(k, rt));
        return (exhit || sbhit) && !m_halted(k);
    endfunction

    function automatic bit m_hf(input int k);
        return accv[k] || ((op == OP_HALT) && !m_stall(k) && en);
    endfunction

    function automatic logic [31:0] m_mask(input int k);
        logic [31:0] m;
        m = '0;
        for (int r = 1; r < NR; r++) m[r] = (E < bu[k][r]);
        return m;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit st [2];
        bit ld;
        if (rst) begin
            E = 0;
            for (int k = 0; k < 2; k++) begin
                accv[k] = 1'b0;
                acc[k]  = 0;
                for (int r = 0; r < NR; r++) bu[k][r] = 0;
            end
            model_on = 1'b1;
        end else if (en) begin
            for (int k = 0; k < 2; k++) st[k] = m_stall(k);
            ld = vld && m_load(exop) && (exrt != 5'd0);
            E++;
            for (int k = 0; k < 2; k++) begin
                if (ld) bu[k][exrt] = E + ll[k] - 1;
                if (!accv[k] && (op == OP_HALT) && !st[k]) begin
                    accv[k] = 1'b1;
                    acc[k]  = E;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            cmp("m1_stall",   {31'd0, s1},  {31'd0, m_stall(0)});
            cmp("m1_ctr",     {31'd0, c1},  {31'd0, m_stall(0)});
            cmp("m1_hfetch",  {31'd0, hf1}, {31'd0, m_hf(0)});
            cmp("m1_halted",  {31'd0, hd1}, {31'd0, m_halted(0)});
            cmp("m1_mask",    m1,           m_mask(0));
            cmp("m3_stall",   {31'd0, s3},  {31'd0, m_stall(1)});
            cmp("m3_ctr",     {31'd0, c3},  {31'd0, m_stall(1)});
            cmp("m3_hfetch",  {31'd0, hf3}, {31'd0, m_hf(1)});
            cmp("m3_halted",  {31'd0, hd3}, {31'd0, m_halted(1)});
            cmp("m3_mask",    m3,           m_mask(1));
        end
    end

    task automatic idle();
        rst = 1'b0; en = 1'b1; vld = 1'b0; exop = OP_R; exrt = 5'd0;
        rs = 5'd0; rt = 5'd0; rt_used = 1'b0; op = OP_R;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        cmp("rst_stall1", {31'd0, s1}, 32'd0);
        cmp("rst_halted1", {31'd0, hd1}, 32'd0);
        cmp("rst_hf1", {31'd0, hf1}, 32'd0);
        cmp("rst_mask3", m3, 32'd0);

        // LW r7 in EX, dependent rs=7 in ID
        idle(); vld = 1'b1; exop = OP_LW; exrt = 5'd7; rs = 5'd7; #2;
        cmp("lu_stall1", {31'd0, s1}, 32'd1);
        cmp("lu_ctr1", {31'd0, c1}, 32'd1);
        cmp("lu_stall3", {31'd0, s3}, 32'd1);
        tick();
        idle(); rs = 5'd7; #2;
        cmp("lu2_stall1", {31'd0, s1}, 32'd0);
        cmp("lu2_stall3", {31'd0, s3}, 32'd1);
        cmp("lu2_mask3", m3, 32'h0000_0080);
        cmp("lu2_mask1", m1, 32'd0);
        tick();
        idle(); rs = 5'd7; #2;
        cmp("lu3_stall3", {31'd0, s3}, 32'd1);
        cmp("lu3_mask3", m3, 32'h0000_0080);
        tick();
        idle(); rs = 5'd7; #2;
        cmp("lu4_stall3", {31'd0, s3}, 32'd0);
        cmp("lu4_mask3", m3, 32'd0);
        tick();

        // r0 load and non-load producer never stall
        idle(); vld = 1'b1; exop = OP_LW; exrt = 5'd0; rs = 5'd0; #2;
        cmp("r0_stall1", {31'd0, s1}, 32'd0);
        cmp("r0_stall3", {31'd0, s3}, 32'd0);
        tick();
        idle(); vld = 1'b1; exop = OP_R; exrt = 5'd3; rs = 5'd3; #2;
        cmp("rtype_stall1", {31'd0, s1}, 32'd0);
        cmp("rtype_stall3", {31'd0, s3}, 32'd0);
        tick();

        // LB r5 against rt, gated by rt_used
        idle(); vld = 1'b1; exop = OP_LB; exrt = 5'd5; rs = 5'd1; rt = 5'd5; #2;
        cmp("rtun_stall1", {31'd0, s1}, 32'd0);
        tick();
        idle(); vld = 1'b1; exop = OP_LB; exrt = 5'd5; rs = 5'd1; rt = 5'd5; rt_used = 1'b1; #2;
        cmp("rtu_stall1", {31'd0, s1}, 32'd1);
        cmp("rtu_stall3", {31'd0, s3}, 32'd1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        #2;
        cmp("drained_mask3", m3, 32'd0);

        // HALT with enable gap mid-drain
        idle(); op = OP_HALT; #2;
        cmp("h_hf1", {31'd0, hf1}, 32'd1);
        cmp("h_hd1", {31'd0, hd1}, 32'd0);
        cmp("h_hf3", {31'd0, hf3}, 32'd1);
        tick();
        idle(); #2;
        cmp("h1_hf1", {31'd0, hf1}, 32'd1);
        cmp("h1_hd1", {31'd0, hd1}, 32'd0);
        tick();
        idle(); en = 1'b0;
        tick();
        #2 cmp("hdis1_hd1", {31'd0, hd1}, 32'd0);
        tick();
        #2 cmp("hdis2_hd1", {31'd0, hd1}, 32'd0);
        en = 1'b1;
        tick();
        #2 cmp("h3_hd1", {31'd0, hd1}, 32'd0);
        tick();
        #2;
        cmp("h4_hd1", {31'd0, hd1}, 32'd1);
        cmp("h4_hd3", {31'd0, hd3}, 32'd1);
        cmp("h4_hf1", {31'd0, hf1}, 32'd1);
        idle(); vld = 1'b1; exop = OP_LW; exrt = 5'd7; rs = 5'd7; #2;
        cmp("halted_nostall1", {31'd0, s1}, 32'd0);
        cmp("halted_nostall3", {31'd0, s3}, 32'd0);
        tick();
        idle(); rst = 1'b1;
        tick();
        idle();

        // Reset while draining with r9 busy
        idle(); vld = 1'b1; exop = OP_LW; exrt = 5'd9; op = OP_HALT; #2;
        cmp("rd_hf3", {31'd0, hf3}, 32'd1);
        tick();
        idle(); #2;
        cmp("rd_mask3", m3, 32'h0000_0200);
        cmp("rd_hf3b", {31'd0, hf3}, 32'd1);
        rst = 1'b1;
        tick();
        idle(); #2;
        cmp("rd_hd3", {31'd0, hd3}, 32'd0);
        cmp("rd_hf3c", {31'd0, hf3}, 32'd0);
        cmp("rd_mask3b", m3, 32'd0);
        cmp("rd_hf1", {31'd0, hf1}, 32'd0);
`ifdef HAZARD_STATS_EN
        cmp("rd_count3", sc3, 32'd0);
`endif

        // Load-use and HALT together in ID
        idle(); vld = 1'b1; exop = OP_LW; exrt = 5'd2; rs = 5'd2; op = OP_HALT; #2;
        cmp("sim_stall1", {31'd0, s1}, 32'd1);
        cmp("sim_hf1", {31'd0, hf1}, 32'd0);
        cmp("sim_ctr3", {31'd0, c3}, 32'd1);
        tick();
        idle(); rs = 5'd2; op = OP_HALT; #2;
        cmp("sim1_stall1", {31'd0, s1}, 32'd0);
        cmp("sim1_hf1", {31'd0, hf1}, 32'd1);
        cmp("sim1_stall3", {31'd0, s3}, 32'd1);
        cmp("sim1_hf3", {31'd0, hf3}, 32'd0);
        tick();
        idle(); rs = 5'd2; op = OP_HALT; #2;
        cmp("sim2_stall3", {31'd0, s3}, 32'd1);
        cmp("sim2_hf3", {31'd0, hf3}, 32'd0);
        tick();
        idle(); rs = 5'd2; op = OP_HALT; #2;
        cmp("sim3_stall3", {31'd0, s3}, 32'd0);
        cmp("sim3_hf3", {31'd0, hf3}, 32'd1);
        tick();
        idle();
        for (int i = 0; i < 6; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Sequential successor to the combinational load-use hazard unit in the MIPS pipeline, sitting between the IF/ID and ID/EX stages.
- Holds a per-register countdown scoreboard so load-use stalls of any configured length can be generated.
- Latches HALT and drains the pipeline for a configured number of cycles before declaring the core halted.
- Drives the stall, bubble-insert and PC-freeze controls consumed by the PC, IF/ID and the ID-stage control mux.

Parameters:
- NB_REG_ADDR, 5, register address width; the scoreboard has 2**NB_REG_ADDR entries.
- NB_OP, 6, opcode width.
- LOAD_LATENCY, 1, bubbles required between a load and a dependent instruction; legal range 1..7.
- DRAIN_CYCLES, 4, cycles from HALT acceptance until o_halted; legal range 1..15.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug-unit step enable; 0 freezes all state.
- i_if_id_rs  in  NB_REG_ADDR  rs of the instruction in ID.
- i_if_id_rt  in  NB_REG_ADDR  rt of the instruction in ID.
- i_if_id_rt_used  in  1  1 when the ID instruction reads rt.
- i_if_id_op  in  NB_OP  opcode of the instruction in ID.
- i_id_ex_rt  in  NB_REG_ADDR  rt (load destination) of the instruction in EX.
- i_id_ex_op  in  NB_OP  opcode of the instruction in EX.
- i_id_ex_valid  in  1  0 when EX holds a bubble.
- o_stall  out  1  hold PC and IF/ID this cycle.
- o_ctr_reg_src  out  1  select zeroed control word into ID/EX (bubble).
- o_halt_fetch  out  1  HALT accepted; PC frozen.
- o_halted  out  1  pipeline drained; sticky.
- o_busy_mask  out  2**NB_REG_ADDR  bit n set when scoreboard entry n is nonzero.

Behaviour:
- is_load(op): op in {CODE_OP_LB, LH, LW, LBU, LHU, LWU}, using the codes.vh definitions.
- Register 0 never creates a hazard and is never written into the scoreboard.
- cnt[n]: 3-bit counter per register; reset value 0.
- ex_hit = i_id_ex_valid & is_load(i_id_ex_op) & (i_id_ex_rt != 0) & (i_id_ex_rt == i_if_id_rs, or i_id_ex_rt == i_if_id_rt with i_if_id_rt_used).
- sb_hit = (rs != 0 & cnt[rs] != 0) | (rt_used & rt != 0 & cnt[rt] != 0).
- o_stall = o_ctr_reg_src = (ex_hit | sb_hit) & ~o_halted. Both are combinational with zero latency.
- Clock edge with i_enable=1 and no reset:
  - all nonzero cnt decrement by 1;
  - then, if EX holds a valid load with rt != 0, cnt[rt] <= LOAD_LATENCY-1. This load has priority over the decrement of the same entry.
- With LOAD_LATENCY=1 the block is exactly a one-bubble load-use detector.
- Halt FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
  - RUN -> DRAIN when i_if_id_op == CODE_OP_HALT, o_stall=0 and i_enable=1. The drain counter loads DRAIN_CYCLES-1.
  - DRAIN: decrements each enabled cycle; moves to HALTED at 0.
  - HALTED: terminal until reset.
- o_halt_fetch = 1 in DRAIN and HALTED, and combinationally in RUN on the accepting cycle.
- o_halted = 1 only in HALTED.
- A HALT held in ID behind a stall is not accepted until the stall clears.
- Loads already in flight continue to count down during DRAIN.
- i_enable=0: counters and FSM hold; outputs are still computed from the current inputs and state.
- i_reset has priority over i_enable, even mid-DRAIN or with the scoreboard busy.
  - Next cycle: all cnt=0, FSM=RUN, o_stall=0 unless ex_hit, o_halted=0.
- Simultaneous events: a load in EX matching ID, with a HALT also present in ID, gives a stall. HALT is accepted the cycle after the stall clears.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds port o_stall_count (out, 32 bits), which counts cycles with o_stall=1 and i_enable=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by i_reset.
  - Frozen once HALTED.
- Undefined: the port and counter are absent and the remaining behaviour is identical.

Test Plan:
- LOAD_LATENCY=1, EX=LW rt=4 valid, ID rs=4 -> o_stall=1 and o_ctr_reg_src=1 that cycle; next cycle (EX bubble) -> o_stall=0.
- LOAD_LATENCY=3, LW rt=7 then ID rs=7 -> o_stall=1 for exactly 3 consecutive cycles; o_busy_mask[7] set for 2 cycles after the load leaves EX.
- EX=LW rt=0 with ID rs=0; also EX=R-type rd=3 with ID rs=3 -> o_stall=0 in both cases.
- EX=LB rt=5 with ID rt=5, first with rt_used=0 -> o_stall=0, then with rt_used=1 -> o_stall=1.
- DRAIN_CYCLES=4, ID op=CODE_OP_HALT -> o_halt_fetch=1 immediately, o_halted=1 after 4 enabled edges; toggling i_enable=0 for 2 cycles mid-drain delays o_halted by 2.
- Assert i_reset during DRAIN with cnt[9]=2 -> next cycle o_halted=0, o_halt_fetch=0, o_busy_mask=0. With HAZARD_STATS_EN, o_stall_count=0.
